// File: rtl/dsp_rd_order_ctrl_if.sv
// Read-path bus bundle for one dispatcher master port.
// Carries the master-side AR/R handshake, the per-slave AR/R handshake vectors,
// the R mux select and the burst-length error pulse.
// Signal names keep the controller's point of view: *_i are controller inputs,
// *_o are controller outputs.
//   slave  modport : the ordering controller
//   master modport : the surrounding logic driving the controller
interface dsp_rd_order_ctrl_if #(
    parameter int unsigned SLV_AMT          = 2,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned TRANS_DATA_LEN_W = 3,
    parameter int unsigned SLV_IDX_W        = 1
);
    logic [ADDR_WIDTH-1:0]       m_ARADDR_i;
    logic [TRANS_DATA_LEN_W-1:0] m_ARLEN_i;
    logic                        m_ARVALID_i;
    logic                        m_ARREADY_o;
    logic [SLV_AMT-1:0]          sa_ARREADY_i;
    logic [SLV_AMT-1:0]          sa_ARVALID_o;
    logic [SLV_AMT-1:0]          sa_AR_outst_full_o;
    logic [SLV_AMT-1:0]          sa_RVALID_i;
    logic [SLV_AMT-1:0]          sa_RLAST_i;
    logic [SLV_AMT-1:0]          sa_RREADY_o;
    logic                        m_RVALID_o;
    logic                        m_RREADY_i;
    logic [SLV_IDX_W-1:0]        r_sel_o;
    logic                        r_len_err_o;

    modport slave (
        input  m_ARADDR_i, m_ARLEN_i, m_ARVALID_i, sa_ARREADY_i,
        input  sa_RVALID_i, sa_RLAST_i, m_RREADY_i,
        output m_ARREADY_o, sa_ARVALID_o, sa_AR_outst_full_o, sa_RREADY_o,
        output m_RVALID_o, r_sel_o, r_len_err_o
    );

    modport master (
        output m_ARADDR_i, m_ARLEN_i, m_ARVALID_i, sa_ARREADY_i,
        output sa_RVALID_i, sa_RLAST_i, m_RREADY_i,
        input  m_ARREADY_o, sa_ARVALID_o, sa_AR_outst_full_o, sa_RREADY_o,
        input  m_RVALID_o, r_sel_o, r_len_err_o
    );
endinterface

// File: rtl/dsp_rd_order_ctrl.sv
// In-order read controller for one master of the dispatcher.
// Routes each AR to the slave decoded from the address, remembers {slave, ARLEN} of
// every accepted AR in a FIFO, and only lets the slave at the FIFO head talk on R.
// The head retires on its RLAST handshake; a beat count that disagrees with ARLEN
// raises a one-cycle r_len_err_o pulse.
// Ports:
//   ACLK_i     clock (rising edge)
//   ARESETn_i  synchronous active-low reset
//   bus        dsp_rd_order_ctrl_if.slave: AR/R handshakes, r_sel_o, r_len_err_o,
//              sa_AR_outst_full_o (FIFO full replicated per slave)
module dsp_rd_order_ctrl #(
    parameter int unsigned SLV_AMT          = 2,
    parameter int unsigned OUTSTANDING_AMT  = 8,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned TRANS_DATA_LEN_W = 3,
    parameter int unsigned SLV_ID_MSB_IDX   = 30,
    parameter int unsigned SLV_ID_LSB_IDX   = 30
) (
    input logic                ACLK_i,
    input logic                ARESETn_i,
    dsp_rd_order_ctrl_if.slave bus
);
    localparam int unsigned SLV_IDX_W = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;
    localparam int unsigned PTR_W     = $clog2(OUTSTANDING_AMT);
    localparam int unsigned CNT_W     = PTR_W + 1;

    typedef enum logic {StEmpty, StFwd} rd_state_e;

    logic [ADDR_WIDTH-1:0]       araddr;
    logic                        unused_araddr;
    logic [SLV_IDX_W-1:0]        ar_idx_raw, ar_idx, head_idx;
    logic [TRANS_DATA_LEN_W-1:0] head_len;
    logic                        full, push, pop, beat, head_last;
    rd_state_e                   state;

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [TRANS_DATA_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                        r_len_err_q, r_len_err_d;

    // Outstanding-transaction FIFO storage; contents are only meaningful below count_q.
    logic [SLV_IDX_W-1:0]        q_idx_q [OUTSTANDING_AMT];
    logic [TRANS_DATA_LEN_W-1:0] q_len_q [OUTSTANDING_AMT];

    assign araddr        = bus.m_ARADDR_i;
    assign unused_araddr = ^araddr;
    assign ar_idx_raw    = araddr[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
    // Addresses beyond the last slave fall onto the last slave.
    assign ar_idx    = (32'(ar_idx_raw) >= SLV_AMT) ? SLV_IDX_W'(SLV_AMT - 1) : ar_idx_raw;

    // full uses the registered count only, so a same-cycle pop never frees an AR slot.
    assign full      = (count_q == CNT_W'(OUTSTANDING_AMT));
    assign state     = (count_q == '0) ? StEmpty : StFwd;
    assign head_idx  = q_idx_q[rd_ptr_q];
    assign head_len  = q_len_q[rd_ptr_q];
    assign head_last = bus.sa_RLAST_i[head_idx];

    assign bus.sa_AR_outst_full_o = {SLV_AMT{full}};
    assign bus.r_len_err_o        = r_len_err_q;

    always_comb begin
        bus.sa_ARVALID_o = '0;
        bus.m_ARREADY_o  = 1'b0;
        bus.sa_RREADY_o  = '0;
        bus.m_RVALID_o   = 1'b0;
        bus.r_sel_o      = '0;
        if (ARESETn_i && !full) begin
            bus.sa_ARVALID_o[ar_idx] = bus.m_ARVALID_i;
            bus.m_ARREADY_o          = bus.sa_ARREADY_i[ar_idx];
        end
        unique case (state)
            StFwd: begin
                bus.r_sel_o = head_idx;
                if (ARESETn_i) begin
                    bus.m_RVALID_o            = bus.sa_RVALID_i[head_idx];
                    bus.sa_RREADY_o[head_idx] = bus.m_RREADY_i;
                end
            end
            default: ;
        endcase
    end

    assign push = bus.m_ARVALID_i & bus.m_ARREADY_o;
    assign beat = bus.m_RVALID_o & bus.m_RREADY_i;
    assign pop  = beat & head_last;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q;
        beat_cnt_d  = beat_cnt_q;
        r_len_err_d = 1'b0;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
        if (beat) begin
            if (head_last) begin
                r_len_err_d = (beat_cnt_q != head_len);
                beat_cnt_d  = '0;
            end else if (beat_cnt_q == head_len) begin
                // Too many beats: flag it and hold the count at ARLEN.
                r_len_err_d = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + TRANS_DATA_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            beat_cnt_q  <= '0;
            r_len_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            beat_cnt_q  <= beat_cnt_d;
            r_len_err_q <= r_len_err_d;
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (push) begin
            q_idx_q[wr_ptr_q] <= ar_idx;
            q_len_q[wr_ptr_q] <= bus.m_ARLEN_i;
        end
    end
endmodule

// File: tb/tb_dsp_rd_order_ctrl.sv
// Scoreboard bench for dsp_rd_order_ctrl: stimulus pushes expected R-order entries,
// a negedge monitor compares DUT outputs against an in-order reference queue.
module tb_dsp_rd_order_ctrl;
    localparam int DEPTH = 8;
    localparam int TMO   = 2000;

    typedef struct {
        int slv;
        int len;
        int act;   // beats-1 the slave will actually send
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsp_rd_order_ctrl_if #(
        .SLV_AMT(2), .ADDR_WIDTH(32), .TRANS_DATA_LEN_W(3), .SLV_IDX_W(1)
    ) bus ();

    dsp_rd_order_ctrl #(
        .SLV_AMT(2), .OUTSTANDING_AMT(DEPTH), .ADDR_WIDTH(32), .TRANS_DATA_LEN_W(3),
        .SLV_ID_MSB_IDX(30), .SLV_ID_LSB_IDX(30)
    ) dut (
        .ACLK_i   (clk),
        .ARESETn_i(rst_n),
        .bus      (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    txn_t        exp_q[$];
    txn_t        pend_q[$];
    int          nbeat    = 0;
    bit          exp_err  = 1'b0;
    int          obs_err  = 0;
    bit          ar_hs    = 1'b0;
    bit [1:0]    r_hs     = '0;
    bit          rst_seen = 1'b0;
    bit [1:0]    slv_en   = '0;
    int unsigned rv_pct   = 70;
    int unsigned rr_pct   = 70;
    bit          ar_rand  = 1'b0;
    bit [1:0]    ar_fix   = 2'b11;
    int          sbeat[2] = '{0, 0};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int find_pend(int s);
        foreach (pend_q[i]) if (pend_q[i].slv == s) return i;
        return -1;
    endfunction

    // Monitor / reference model.
    always @(negedge clk) begin : mon
        bit   full;
        int   idx;
        txn_t h;
        bit   last;
        if (!rst_n) begin
            chk("rst_m_arready", 32'(bus.m_ARREADY_o), 0);
            chk("rst_sa_arvalid", 32'(bus.sa_ARVALID_o), 0);
            chk("rst_sa_rready", 32'(bus.sa_RREADY_o), 0);
            chk("rst_m_rvalid", 32'(bus.m_RVALID_o), 0);
            exp_q.delete();
            nbeat    = 0;
            exp_err  = 1'b0;
            ar_hs    = 1'b0;
            r_hs     = '0;
            rst_seen = 1'b1;
        end else begin
            chk("r_len_err", 32'(bus.r_len_err_o), 32'(exp_err));
            if (bus.r_len_err_o) obs_err++;
            exp_err = 1'b0;
            full = (exp_q.size() == DEPTH);
            idx  = int'(bus.m_ARADDR_i[30]);
            chk("outst_full", 32'(bus.sa_AR_outst_full_o), full ? 32'd3 : 32'd0);
            chk("sa_arvalid", 32'(bus.sa_ARVALID_o),
                (bus.m_ARVALID_i && !full) ? (32'd1 << idx) : 32'd0);
            chk("m_arready", 32'(bus.m_ARREADY_o), 32'(!full && bus.sa_ARREADY_i[idx]));
            ar_hs = bus.m_ARVALID_i && !full && bus.sa_ARREADY_i[idx];
            r_hs  = bus.sa_RVALID_i & bus.sa_RREADY_o;
            if (exp_q.size() == 0) begin
                chk("empty_m_rvalid", 32'(bus.m_RVALID_o), 0);
                chk("empty_sa_rready", 32'(bus.sa_RREADY_o), 0);
            end else begin
                h = exp_q[0];
                chk("r_sel", 32'(bus.r_sel_o), 32'(h.slv));
                chk("m_rvalid", 32'(bus.m_RVALID_o), 32'(bus.sa_RVALID_i[h.slv]));
                chk("sa_rready", 32'(bus.sa_RREADY_o), bus.m_RREADY_i ? (32'd1 << h.slv) : 0);
                if (bus.sa_RVALID_i[h.slv] && bus.m_RREADY_i) begin
                    last    = (nbeat == h.act);
                    exp_err = last ? (nbeat < h.len) : (nbeat >= h.len);
                    if (last) begin
                        void'(exp_q.pop_front());
                        nbeat = 0;
                    end else begin
                        nbeat++;
                    end
                end
            end
        end
    end

    // Slave responders, master R ready and slave AR ready.
    always begin : bfm
        logic [1:0] rv, rl;
        int         k;
        @(posedge clk);
        #1;
        rv = bus.sa_RVALID_i & ~r_hs;
        rl = bus.sa_RLAST_i;
        if (rst_seen) begin
            pend_q.delete();
            sbeat[0] = 0;
            sbeat[1] = 0;
            rv       = '0;
            rst_seen = 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (r_hs[s]) begin
                    k = find_pend(s);
                    if (k >= 0) begin
                        if (sbeat[s] == pend_q[k].act) begin
                            pend_q.delete(k);
                            sbeat[s] = 0;
                        end else begin
                            sbeat[s]++;
                        end
                    end
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            k = find_pend(s);
            if (k < 0) begin
                rv[s] = 1'b0;
                rl[s] = 1'b0;
            end else begin
                if (!rv[s]) rv[s] = slv_en[s] && ($urandom_range(0, 99) < rv_pct);
                rl[s] = (sbeat[s] == pend_q[k].act);
            end
        end
        bus.sa_RVALID_i  = rv;
        bus.sa_RLAST_i   = rl;
        bus.m_RREADY_i   = ($urandom_range(0, 99) < rr_pct);
        bus.sa_ARREADY_i = ar_rand ? 2'($urandom) : ar_fix;
    end

    task automatic issue_ar(input int slv, input int len, input int act);
        logic [31:0] a;
        a = $urandom;
        a[30] = slv[0];
        bus.m_ARADDR_i  = a;
        bus.m_ARLEN_i   = 3'(len);
        bus.m_ARVALID_i = 1'b1;
        for (int t = 0; t < TMO; t++) begin
            @(posedge clk);
            #1;
            if (ar_hs) begin
                exp_q.push_back('{slv, len, act});
                pend_q.push_back('{slv, len, act});
                bus.m_ARVALID_i = 1'b0;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL ar_accept_timeout: got no AR handshake, expected one within %0d cycles", TMO);
        bus.m_ARVALID_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < TMO; t++) begin
            if (exp_q.size() == 0 && pend_q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_drain_timeout: got %0d outstanding, expected 0", name, exp_q.size());
    endtask

    initial begin
        int e0;
        int t;
        bus.m_ARADDR_i   = '0;
        bus.m_ARLEN_i    = '0;
        bus.m_ARVALID_i  = 1'b0;
        bus.sa_ARREADY_i = '0;
        bus.sa_RVALID_i  = '0;
        bus.sa_RLAST_i   = '0;
        bus.m_RREADY_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single AR routed to slave 1, head visible one cycle later.
        ar_fix = 2'b10;
        slv_en = 2'b00;
        @(posedge clk);
        #1;
        bus.m_ARADDR_i  = 32'h4000_0000;
        bus.m_ARLEN_i   = 3'd3;
        bus.m_ARVALID_i = 1'b1;
        @(negedge clk);
        chk("t1_sa_arvalid", 32'(bus.sa_ARVALID_o), 32'h2);
        chk("t1_m_arready", 32'(bus.m_ARREADY_o), 1);
        @(posedge clk);
        #1;
        if (ar_hs) begin
            exp_q.push_back('{1, 3, 3});
            pend_q.push_back('{1, 3, 3});
        end
        bus.m_ARVALID_i = 1'b0;
        @(negedge clk);
        chk("t1_r_sel", 32'(bus.r_sel_o), 1);
        @(posedge clk);
        #1;
        ar_fix = 2'b11;
        slv_en = 2'b11;
        wait_idle("t1");

        // 2: slave 1 answers first but is stalled behind slave 0.
        rv_pct = 100;
        rr_pct = 100;
        slv_en = 2'b10;
        issue_ar(0, 1, 1);
        issue_ar(1, 0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t2_stall_rready", 32'(bus.sa_RREADY_o), 32'h1);
        chk("t2_stall_rvalid", 32'(bus.m_RVALID_o), 0);
        @(posedge clk);
        #1;
        slv_en = 2'b11;
        wait_idle("t2");

        // 3: fill all 8 slots, then pop with an AR waiting.
        slv_en = 2'b00;
        for (int i = 0; i < DEPTH; i++) issue_ar(i % 2, 0, 0);
        @(negedge clk);
        chk("t3_full", 32'(bus.sa_AR_outst_full_o), 32'h3);
        chk("t3_arready", 32'(bus.m_ARREADY_o), 0);
        @(posedge clk);
        #1;
        slv_en = 2'b11;
        issue_ar(0, 0, 0);
        wait_idle("t3");

        // 4: len=2 burst terminated early by RLAST on beat 1.
        rv_pct = 70;
        rr_pct = 70;
        e0 = obs_err;
        issue_ar(1, 2, 1);
        wait_idle("t4");
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_pulses", 32'(obs_err - e0), 1);

        // 5: reset in the middle of a burst with 5 outstanding.
        slv_en = 2'b00;
        for (int i = 0; i < 5; i++) issue_ar(i % 2, 3, 3);
        rv_pct = 100;
        rr_pct = 100;
        slv_en = 2'b01;
        t = 0;
        while (nbeat == 0 && t < TMO) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("t5_midburst_reached", 32'(nbeat > 0), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_m_rvalid", 32'(bus.m_RVALID_o), 0);
        chk("t5_sa_rready", 32'(bus.sa_RREADY_o), 0);
        chk("t5_full", 32'(bus.sa_AR_outst_full_o), 0);
        @(posedge clk);
        #1;
        slv_en = 2'b11;

        // 6: 20 alternating back-to-back transactions across pointer wrap.
        rv_pct  = 80;
        rr_pct  = 80;
        ar_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            t = int'($urandom_range(0, 3));
            issue_ar(i % 2, t, t);
        end
        wait_idle("t6");

        // 7: random mix with occasional wrong burst lengths.
        rv_pct = 60;
        rr_pct = 60;
        for (int i = 0; i < 60; i++) begin
            int l;
            int a;
            l = int'($urandom_range(0, 7));
            a = ($urandom_range(0, 99) < 15) ? int'($urandom_range(0, 7)) : l;
            issue_ar(int'($urandom_range(0, 1)), l, a);
        end
        wait_idle("t7");
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: got no end of test, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
